// File: rtl/sdram_write.sv
// Single-burst SDRAM write engine: ACTIVE, tRCD, WRITE, full-page data, BURST STOP,
// tWR, PRECHARGE, tRP, done. Commands are registered; FIFO pop and wr_end are combinational.
module sdram_write #(
  parameter logic [9:0] TRCD_CLK = 10'd2,
  parameter logic [9:0] TWR_CLK  = 10'd2,
  parameter logic [9:0] TRP_CLK  = 10'd2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic        wr_en,
  input  logic [23:0] wr_addr,
  input  logic [9:0]  wr_burst_len,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  output logic        wr_end,
  output logic [3:0]  write_cmd,
  output logic [1:0]  write_ba,
  output logic [12:0] write_addr,
  output logic        wr_sdram_en,
  output logic [15:0] wr_sdram_data
);

  localparam logic [3:0]  CmdNop     = 4'b0111;
  localparam logic [3:0]  CmdActive  = 4'b0011;
  localparam logic [3:0]  CmdWrite   = 4'b0100;
  localparam logic [3:0]  CmdBStop   = 4'b0110;
  localparam logic [3:0]  CmdPCharge = 4'b0010;
  localparam logic [1:0]  IdleBa     = 2'b11;
  localparam logic [12:0] IdleAddr   = 13'h1fff;

  typedef enum logic [3:0] {
    StIdle, StActive, StTrcd, StWrite, StData, StTwr, StPre, StTrp, StEnd
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [9:0]  r_cnt_clk;
  logic [9:0]  w_cnt_nxt;
  logic [23:0] r_addr;
  logic [9:0]  r_len;
  logic [3:0]  r_cmd;
  logic [1:0]  r_ba;
  logic [12:0] r_bus_addr;
  logic        r_sdram_en;
  logic [3:0]  w_cmd;
  logic [1:0]  w_ba;
  logic [12:0] w_bus_addr;
  logic        w_start;
  logic        w_last;

  assign w_start = (r_state == StIdle) && wr_en && init_end;
  assign w_last  = (r_cnt_clk == r_len - 10'd1);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (w_start) w_state_nxt = StActive;
      StActive: w_state_nxt = StTrcd;
      StTrcd:   if (r_cnt_clk == TRCD_CLK) w_state_nxt = StWrite;
      StWrite:  w_state_nxt = StData;
      StData:   if (w_last) w_state_nxt = StTwr;
      StTwr:    if (r_cnt_clk == TWR_CLK) w_state_nxt = StPre;
      StPre:    w_state_nxt = StTrp;
      StTrp:    if (r_cnt_clk == TRP_CLK) w_state_nxt = StEnd;
      StEnd:    w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // Counter restarts from zero on every state change, so each wait begins at 0.
  assign w_cnt_nxt = (w_state_nxt != r_state) ? 10'd0 : r_cnt_clk + 10'd1;

  always_comb begin
    w_cmd      = CmdNop;
    w_ba       = IdleBa;
    w_bus_addr = IdleAddr;
    unique case (r_state)
      StActive: begin
        w_cmd      = CmdActive;
        w_ba       = r_addr[23:22];
        w_bus_addr = r_addr[21:9];
      end
      StWrite: begin
        w_cmd      = CmdWrite;
        w_ba       = r_addr[23:22];
        w_bus_addr = {4'b0000, r_addr[8:0]};
      end
      StData: begin
        if (w_last) begin
          w_cmd      = CmdBStop;
          w_ba       = r_ba;
          w_bus_addr = r_bus_addr;
        end
      end
      StPre: begin
        w_cmd      = CmdPCharge;
        w_ba       = r_addr[23:22];
        w_bus_addr = 13'h0400;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= StIdle;
      r_cnt_clk  <= 10'd0;
      r_addr     <= 24'd0;
      r_len      <= 10'd0;
      r_cmd      <= CmdNop;
      r_ba       <= IdleBa;
      r_bus_addr <= IdleAddr;
      r_sdram_en <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt_clk  <= w_cnt_nxt;
      r_cmd      <= w_cmd;
      r_ba       <= w_ba;
      r_bus_addr <= w_bus_addr;
      r_sdram_en <= wr_ack;
      if (w_start) begin
        r_addr <= wr_addr;
        r_len  <= wr_burst_len;
      end
    end
  end

  // One pop in WRITE plus len-1 in DATA; the registered enable lines word 0 up with WRITE.
  assign wr_ack        = (r_state == StWrite) || ((r_state == StData) && (r_cnt_clk < r_len - 10'd1));
  assign wr_end        = (r_state == StEnd);
  assign write_cmd     = r_cmd;
  assign write_ba      = r_ba;
  assign write_addr    = r_bus_addr;
  assign wr_sdram_en   = r_sdram_en;
  assign wr_sdram_data = r_sdram_en ? wr_data : 16'd0;

endmodule

// File: tb/tb_sdram_write.sv
// Directed bench for sdram_write: per-cycle traces of each burst are captured and
// compared against hand-computed cycle positions and values.
module tb_sdram_write;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] WRT = 4'b0100;
  localparam logic [3:0] BST = 4'b0110;
  localparam logic [3:0] PCH = 4'b0010;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        init_end = 1'b0;
  logic        wr_en = 1'b0;
  logic [23:0] wr_addr = '0;
  logic [9:0]  wr_burst_len = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ack;
  logic        wr_end;
  logic [3:0]  write_cmd;
  logic [1:0]  write_ba;
  logic [12:0] write_addr;
  logic        wr_sdram_en;
  logic [15:0] wr_sdram_data;

  int n_checks = 0;
  int n_errors = 0;
  int pop_cnt = 0;
  int pop_base;

  logic [3:0]  t_cmd  [600];
  logic [1:0]  t_ba   [600];
  logic [12:0] t_addr [600];
  logic        t_ack  [600];
  logic        t_en   [600];
  logic [15:0] t_data [600];
  logic        t_end  [600];

  sdram_write dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .init_end      (init_end),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_burst_len  (wr_burst_len),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
    .wr_end        (wr_end),
    .write_cmd     (write_cmd),
    .write_ba      (write_ba),
    .write_addr    (write_addr),
    .wr_sdram_en   (wr_sdram_en),
    .wr_sdram_data (wr_sdram_data)
  );

  always #5 sys_clk = ~sys_clk;

  // Upstream FIFO model: word n is 16'h1000 + n, presented the cycle after its pop.
  always @(posedge sys_clk) begin
    if (wr_ack) begin
      wr_data <= 16'h1000 + pop_cnt[15:0];
      pop_cnt <= pop_cnt + 1;
    end
  end

  function automatic logic [15:0] word(input int n);
    word = 16'h1000 + n[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Cycle 0 is the IDLE cycle in which the request is presented.
  task automatic run(input logic [23:0] a, input logic [9:0] len, input int n, input bit hold,
                     input logic [23:0] a2, input int chg_k);
    wr_addr      = a;
    wr_burst_len = len;
    wr_en        = 1'b1;
    pop_base     = pop_cnt;
    for (int k = 0; k < n; k++) begin
      t_cmd[k]  = write_cmd;
      t_ba[k]   = write_ba;
      t_addr[k] = write_addr;
      t_ack[k]  = wr_ack;
      t_en[k]   = wr_sdram_en;
      t_data[k] = wr_sdram_data;
      t_end[k]  = wr_end;
      step();
      if (!hold) wr_en = 1'b0;
      if (k == chg_k) wr_addr = a2;
    end
  endtask

  initial begin
    int c_ack, c_en, c_cmd, c_end, found;
    logic [31:0] m_ack, m_en, m_end;

    step();
    step();
    check("rst_cmd", {28'd0, write_cmd}, {28'd0, NOP});
    check("rst_ba", {30'd0, write_ba}, 32'd3);
    check("rst_addr", {19'd0, write_addr}, 32'h1fff);
    check("rst_en_ack_end", {29'd0, wr_sdram_en, wr_ack, wr_end}, 32'd0);
    sys_rst = 1'b0;
    step();
    check("idle_cmd", {28'd0, write_cmd}, {28'd0, NOP});

    // wr_en with init_end low must be ignored
    wr_addr = 24'hC0_0205;
    wr_burst_len = 10'd4;
    wr_en = 1'b1;
    c_cmd = 0;
    c_ack = 0;
    for (int k = 0; k < 20; k++) begin
      if (write_cmd != NOP) c_cmd++;
      if (wr_ack) c_ack++;
      step();
    end
    check("gate_cmds", c_cmd, 0);
    check("gate_acks", c_ack, 0);
    wr_en = 1'b0;
    step();
    init_end = 1'b1;
    step();

    // Reset asserted while WRITE is on the bus
    run(24'h40_0003, 10'd8, 6, 1'b0, 24'h40_0003, -1);
    check("prerst_cmd", {28'd0, write_cmd}, {28'd0, WRT});
    check("prerst_en", {31'd0, wr_sdram_en}, 32'd1);
    sys_rst = 1'b1;
    #1;
    check("midrst_cmd", {28'd0, write_cmd}, {28'd0, NOP});
    check("midrst_ba_addr", {17'd0, write_ba, write_addr}, {17'd0, 2'b11, 13'h1fff});
    check("midrst_en_ack_end", {29'd0, wr_sdram_en, wr_ack, wr_end}, 32'd0);
    check("midrst_data", {16'd0, wr_sdram_data}, 32'd0);
    step();
    sys_rst = 1'b0;
    step();
    c_cmd = 0;
    c_ack = 0;
    for (int k = 0; k < 10; k++) begin
      if (write_cmd != NOP) c_cmd++;
      if (wr_ack) c_ack++;
      step();
    end
    check("postrst_no_cmd", c_cmd, 0);
    check("postrst_no_ack", c_ack, 0);

    // len=4, bank 3 row 1 col 5
    run(24'hC0_0205, 10'd4, 20, 1'b0, 24'hC0_0205, -1);
    m_ack = '0;
    m_en = '0;
    m_end = '0;
    c_cmd = 0;
    for (int k = 0; k < 20; k++) begin
      m_ack[k] = t_ack[k];
      m_en[k]  = t_en[k];
      m_end[k] = t_end[k];
      if (t_cmd[k] != NOP) c_cmd++;
    end
    check("b4_act_cmd", {28'd0, t_cmd[2]}, {28'd0, ACT});
    check("b4_act_ba_addr", {17'd0, t_ba[2], t_addr[2]}, {17'd0, 2'd3, 13'h0001});
    check("b4_wr_cmd", {28'd0, t_cmd[6]}, {28'd0, WRT});
    check("b4_wr_ba_addr", {17'd0, t_ba[6], t_addr[6]}, {17'd0, 2'd3, 13'h0005});
    check("b4_ack_mask", m_ack, 32'h0000_01E0);
    check("b4_en_mask", m_en, 32'h0000_03C0);
    for (int i = 0; i < 4; i++) check("b4_data", {16'd0, t_data[6+i]}, {16'd0, word(pop_base + i)});
    check("b4_bstop", {28'd0, t_cmd[10]}, {28'd0, BST});
    check("b4_pch_cmd", {28'd0, t_cmd[14]}, {28'd0, PCH});
    check("b4_pch_ba_addr", {17'd0, t_ba[14], t_addr[14]}, {17'd0, 2'd3, 13'h0400});
    check("b4_end_mask", m_end, 32'h0002_0000);
    check("b4_cmd_count", c_cmd, 4);
    check("b4_pops", pop_cnt - pop_base, 4);

    // len=1
    run(24'h00_0009, 10'd1, 18, 1'b0, 24'h00_0009, -1);
    c_ack = 0;
    c_en = 0;
    for (int k = 0; k < 18; k++) begin
      if (t_ack[k]) c_ack++;
      if (t_en[k]) c_en++;
    end
    check("l1_ack_count", c_ack, 1);
    check("l1_en_count", c_en, 1);
    check("l1_ack_pos", {31'd0, t_ack[5]}, 32'd1);
    check("l1_en_pos", {31'd0, t_en[6]}, 32'd1);
    check("l1_data", {16'd0, t_data[6]}, {16'd0, word(pop_base)});
    check("l1_bstop", {28'd0, t_cmd[7]}, {28'd0, BST});
    check("l1_end", {31'd0, t_end[14]}, 32'd1);

    // len=512, bank 2, wr_addr changed mid-burst
    run(24'h80_1234, 10'd512, 530, 1'b0, 24'h40_0000, 100);
    c_ack = 0;
    for (int k = 0; k < 530; k++) if (t_ack[k]) c_ack++;
    check("l512_ack_count", c_ack, 512);
    check("l512_pops", pop_cnt - pop_base, 512);
    check("l512_last_data", {16'd0, t_data[517]}, {16'd0, word(pop_base + 511)});
    check("l512_bstop", {28'd0, t_cmd[518]}, {28'd0, BST});
    check("l512_pch_cmd", {28'd0, t_cmd[522]}, {28'd0, PCH});
    check("l512_pch_ba", {30'd0, t_ba[522]}, 32'd2);
    check("l512_end", {31'd0, t_end[525]}, 32'd1);

    // Back-to-back with wr_en held: second address presented from cycle 2
    run(24'h00_0000, 10'd2, 20, 1'b1, 24'h40_0C07, 1);
    wr_en = 1'b0;
    check("b2b_end", {31'd0, t_end[15]}, 32'd1);
    check("b2b_gap_cmds", {24'd0, t_cmd[16], t_cmd[17]}, {24'd0, NOP, NOP});
    check("b2b_act2_cmd", {28'd0, t_cmd[18]}, {28'd0, ACT});
    check("b2b_act2_ba_addr", {17'd0, t_ba[18], t_addr[18]}, {17'd0, 2'd1, 13'h0006});
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      if (wr_end) found = 1;
      step();
    end
    check("b2b_second_end", found, 1);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdram_write.md
Name: sdram_write

Overview:
- Single-burst SDRAM write engine: ACTIVE, tRCD wait, WRITE, full-page burst data, BURST STOP, tWR wait, PRECHARGE, tRP wait, done.
- Sits beside the SDRAM read engine under the SDRAM controller arbiter, which muxes its cmd/ba/addr onto the SDRAM pins.
- Pulls write data from the upstream write FIFO with a read-request handshake.
- Drives the DQ bus and its output enable.

Parameters:
TRCD_CLK, 10'd2, TRCD wait exits at cnt_clk == TRCD_CLK (3 cycles in TRCD)
TWR_CLK, 10'd2, TWR wait exits at cnt_clk == TWR_CLK (3 cycles)
TRP_CLK, 10'd2, TRP wait exits at cnt_clk == TRP_CLK (3 cycles)

Ports:
sys_clk  in  1  system clock, 100 MHz
sys_rst  in  1  asynchronous reset, active-high
init_end  in  1  SDRAM initialisation complete
wr_en  in  1  write request from arbiter
wr_addr  in  24  {bank[23:22], row[21:9], col[8:0]}
wr_burst_len  in  10  words per burst, legal 1..512
wr_data  in  16  FIFO output, valid the cycle after wr_ack
wr_ack  out  1  FIFO read request, combinational
wr_end  out  1  one-cycle burst-complete pulse, combinational
write_cmd  out  4  {CS_N,RAS_N,CAS_N,WE_N}, registered
write_ba  out  2  bank address, registered
write_addr  out  13  SDRAM address bus, registered
wr_sdram_en  out  1  DQ output enable, registered
wr_sdram_data  out  16  DQ drive value

Behaviour:
- Commands:
  - NOP 4'b0111, ACTIVE 4'b0011, WRITE 4'b0100, B_STOP 4'b0110, P_CHARGE 4'b0010.
  - Idle bus values: ba 2'b11, addr 13'h1fff.
- Reset (async, sys_rst=1):
  - State WR_IDLE, cnt_clk=0.
  - write_cmd=NOP, write_ba=2'b11, write_addr=13'h1fff, wr_sdram_en=0.
  - Latched address and length are 0.
  - wr_ack=0, wr_end=0, wr_sdram_data=0.
  - A reset in mid-burst aborts immediately to these values. No precharge is issued.
- States: IDLE, ACTIVE, TRCD, WRITE, DATA, TWR, PRE, TRP, END.
- Counter: cnt_clk counts up every cycle and clears on entry to each wait/data state.
- Transitions:
  - IDLE -> ACTIVE when wr_en && init_end. wr_addr and wr_burst_len are latched in the same cycle.
  - wr_en is ignored outside IDLE, and ignored while init_end=0.
  - ACTIVE -> TRCD (1 cycle).
  - TRCD -> WRITE at cnt_clk==TRCD_CLK.
  - WRITE -> DATA (1 cycle).
  - DATA -> TWR at cnt_clk==len-1 (len cycles in DATA).
  - TWR -> PRE at cnt_clk==TWR_CLK.
  - PRE -> TRP (1 cycle).
  - TRP -> END at cnt_clk==TRP_CLK.
  - END -> IDLE (1 cycle).
- Command outputs are registered: the value in cycle N+1 reflects the state in cycle N.
  - ACTIVE: ba = latched bank, addr = row.
  - WRITE: ba = bank, addr = {4'b0000, col}. A10=0, so no auto-precharge.
  - DATA at cnt_clk==len-1: B_STOP, ba/addr unchanged.
  - PRE: P_CHARGE, ba = bank, addr = 13'h0400 (all banks).
  - All other states: NOP with the idle ba/addr values.
- Data path:
  - wr_ack = (state==WRITE) || (state==DATA && cnt_clk < len-1), giving exactly len cycles.
  - wr_sdram_en = wr_ack delayed 1 cycle, so the first word coincides with the WRITE command on the bus.
  - wr_sdram_data = wr_data when wr_sdram_en=1, else 0.
  - B_STOP lands on the cycle after the last data word.
- len==1: wr_ack only in WRITE; DATA lasts 1 cycle and issues B_STOP.
- wr_end = (state==END).

Test Plan:
- Reset/idle: assert sys_rst mid-sequence -> all outputs at reset values in the same cycle. After release, state IDLE and write_cmd=NOP.
- Gating: wr_en=1 with init_end=0 for 20 cycles -> write_cmd stays NOP and wr_ack=0.
- Burst len=4, wr_addr=24'hC0_0205 (bank 3, row 1, col 5), wr_en accepted at cycle 0:
  - ACTIVE on bus at cycle 2, with ba=3 and addr=13'h0001.
  - WRITE on bus at cycle 6, with addr=13'h0005.
  - wr_ack high cycles 5–8; wr_sdram_en high cycles 6–9 carrying FIFO words D0–D3.
  - B_STOP at cycle 10; P_CHARGE at cycle 14 with addr 13'h0400.
  - wr_end pulses at cycle 17.
- len=1: exactly one wr_ack and one wr_sdram_en cycle; B_STOP on the cycle after the single data word.
- len=512: wr_ack high for exactly 512 cycles; no extra FIFO pops; changing wr_addr mid-burst does not change write_ba on PRE.
- Back-to-back: wr_en held high -> second ACTIVE is issued 3 cycles after wr_end, with the second address latched.
